// File: rtl/game_pkg.sv
// Shared types and helpers for the per-player game logic.
// Decodes the state bus and qualifies coin values.
package game_pkg;

    typedef enum logic [1:0] {
        MENU = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } game_state_t;

    localparam int HP_W         = 4;
    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_W      = 4 * SCORE_DIGITS;

    typedef logic [3:0] bcd_digit_t;

    // The unused 2'b11 encoding is folded into MENU.
    function automatic game_state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'b01:   return PLAY;
            2'b10:   return OVER;
            default: return MENU;
        endcase
    endfunction

    function automatic logic coin_valid(input logic [3:0] v);
        return (v != 4'd0) && (v <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with carry in/out.
// The operands are assumed to be valid BCD digits.
module bcd_digit_add
    import game_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout
);

    logic [4:0] raw;

    assign raw  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    assign cout = (raw > 5'd9);
    // For raw 10..19, adding 6 to the low nibble wraps it to raw-10.
    assign sum  = cout ? (raw[3:0] + 4'd6) : raw[3:0];

endmodule

// File: rtl/player_status.sv
// Per-player hp, invulnerability window, BCD score and high score tracker.
// Every output is registered, so an event shows up one clock after it is sampled.
module player_status
    import game_pkg::*;
#(
    parameter logic [HP_W-1:0] HP_MAX        = 4'd8,
    parameter logic [HP_W-1:0] HIT_DMG       = 4'd1,
    parameter logic [7:0]      INVULN_FRAMES = 8'd60
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_tick,
    input  logic [1:0]          game_state,
    input  logic                game_reset,
    input  logic                score_reset,
    input  logic                hit,
    input  logic                heal,
    input  logic                coin,
    input  logic [3:0]          coin_val,
    output logic [HP_W-1:0]     hp,
    output logic                invuln,
    output logic                dead,
    output logic [SCORE_W-1:0]  score_bcd,
    output logic [SCORE_W-1:0]  hi_score_bcd
);

    game_state_t          state_now;
    game_state_t          prev_state_q;

    logic                 in_play;
    logic                 tick_ok;
    logic                 hit_ok;
    logic                 heal_ok;
    logic                 coin_ok;
    logic                 leaving_play;

    logic [HP_W-1:0]      hp_q, hp_d;
    logic                 invuln_q, invuln_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 dead_q, dead_d;

    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W-1:0]   hi_q, hi_d;
    logic [SCORE_W-1:0]   score_sum;
    logic [SCORE_W-1:0]   score_sat;
    logic [SCORE_DIGITS:0] carry;

    assign state_now    = decode_state(game_state);
    assign in_play      = (state_now == PLAY);
    assign leaving_play = (prev_state_q == PLAY) && !in_play;

    assign tick_ok = frame_tick && in_play;
    assign hit_ok  = hit  && in_play && !invuln_q && (hp_q != '0);
    assign heal_ok = heal && in_play && (hp_q != '0);
    assign coin_ok = coin && in_play && coin_valid(coin_val);

    // Coin value enters at the least significant digit and ripples upward.
    assign carry[0] = 1'b0;
    for (genvar g = 0; g < SCORE_DIGITS; g++) begin : g_digit
        bcd_digit_add u_add (
            .a    (score_q[4*g +: 4]),
            .b    ((g == 0) ? coin_val : 4'd0),
            .cin  (carry[g]),
            .sum  (score_sum[4*g +: 4]),
            .cout (carry[g+1])
        );
    end

    assign score_sat = carry[SCORE_DIGITS] ? {SCORE_DIGITS{4'h9}} : score_sum;

    always_comb begin
        hp_d     = hp_q;
        invuln_d = invuln_q;
        cnt_d    = cnt_q;

        if (game_reset) begin
            hp_d     = HP_MAX;
            invuln_d = 1'b0;
            cnt_d    = '0;
        end else begin
            if (tick_ok && (cnt_q != '0)) begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    invuln_d = 1'b0;
                end
            end

            // hit_ok looks at the registered invuln, so a hit landing on the
            // closing tick is still rejected.
            if (hit_ok) begin
                hp_d     = (hp_q > HIT_DMG) ? (hp_q - HIT_DMG) : '0;
                invuln_d = 1'b1;
                cnt_d    = INVULN_FRAMES;
            end else if (heal_ok) begin
                hp_d = (hp_q >= HP_MAX) ? HP_MAX : (hp_q + HP_W'(1));
            end
        end

        dead_d = (hp_d == '0);
    end

    always_comb begin
        score_d = score_q;
        hi_d    = hi_q;

        if (score_reset) begin
            score_d = '0;
        end else if (coin_ok) begin
            score_d = score_sat;
        end

        // Valid BCD orders the same way as plain unsigned binary.
        if (leaving_play && (score_q > hi_q)) begin
            hi_d = score_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hp_q         <= HP_MAX;
            invuln_q     <= 1'b0;
            cnt_q        <= '0;
            dead_q       <= 1'b0;
            score_q      <= '0;
            hi_q         <= '0;
            prev_state_q <= MENU;
        end else begin
            hp_q         <= hp_d;
            invuln_q     <= invuln_d;
            cnt_q        <= cnt_d;
            dead_q       <= dead_d;
            score_q      <= score_d;
            hi_q         <= hi_d;
            prev_state_q <= state_now;
        end
    end

    assign hp           = hp_q;
    assign invuln       = invuln_q;
    assign dead         = dead_q;
    assign score_bcd    = score_q;
    assign hi_score_bcd = hi_q;

endmodule

// File: tb/tb_player_status.sv
// Scoreboard bench for player_status: expectations are queued with the stimulus
// and popped one clock later when the registered outputs have updated.
module tb_player_status;
    import game_pkg::*;

    typedef struct packed {
        logic [3:0]  hp;
        logic        inv;
        logic        dead;
        logic [15:0] score;
        logic [15:0] hi;
    } obs_t;

    logic        Clk = 1'b0;
    logic        Reset, frame_tick, game_reset, score_reset, hit, heal, coin;
    logic [1:0]  game_state;
    logic [3:0]  coin_val;

    logic [3:0]  hp_a, hp_b;
    logic        invuln_a, invuln_b, dead_a, dead_b;
    logic [15:0] score_a, score_b, hi_a, hi_b;

    obs_t obs_a, obs_b, e;
    obs_t exp_q[$];
    obs_t expb_q[$];

    int checks = 0;
    int errors = 0;
    int m_score;

    logic [3:0] dead_stim [12];
    logic [5:0] dead_exp  [12];

    always #5 Clk = ~Clk;

    assign obs_a = {hp_a, invuln_a, dead_a, score_a, hi_a};
    assign obs_b = {hp_b, invuln_b, dead_b, score_b, hi_b};

    player_status dut_a (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_state(game_state),
        .game_reset(game_reset), .score_reset(score_reset), .hit(hit), .heal(heal),
        .coin(coin), .coin_val(coin_val), .hp(hp_a), .invuln(invuln_a), .dead(dead_a),
        .score_bcd(score_a), .hi_score_bcd(hi_a)
    );

    player_status #(.HIT_DMG(4'd3), .INVULN_FRAMES(8'd1)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .game_state(game_state),
        .game_reset(game_reset), .score_reset(score_reset), .hit(hit), .heal(heal),
        .coin(coin), .coin_val(coin_val), .hp(hp_b), .invuln(invuln_b), .dead(dead_b),
        .score_bcd(score_b), .hi_score_bcd(hi_b)
    );

    function automatic obs_t mk(input logic [3:0] h, input logic i, input logic d,
                                input logic [15:0] s, input logic [15:0] hs);
        return {h, i, d, s, hs};
    endfunction

    // Decimal reference, independent of any digit-wise carry logic.
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic cycle();
        @(posedge Clk);
        #1;
        hit = 0; heal = 0; coin = 0; frame_tick = 0; game_reset = 0; score_reset = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        cycle();
        Reset = 0;
        exp_q.delete();
        expb_q.delete();
    endtask

    task automatic test_reset();
        Reset = 1; game_state = PLAY; hit = 1; coin = 1; coin_val = 4'd5; frame_tick = 1;
        exp_q.push_back(mk(4'd8, 0, 0, 16'h0, 16'h0));
        expb_q.push_back(mk(4'd8, 0, 0, 16'h0, 16'h0));
        cycle();
        Reset = 0;
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL reset_a: got %h want %h", obs_a, e); end
        e = expb_q.pop_front(); checks++;
        if (obs_b !== e) begin errors++; $display("FAIL reset_b: got %h want %h", obs_b, e); end
    endtask

    task automatic test_hit();
        game_state = PLAY;
        hit = 1;
        exp_q.push_back(mk(4'd7, 1, 0, 16'h0, 16'h0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL hit_accept: got %h want %h", obs_a, e); end
        for (int i = 0; i < 3; i++) begin
            hit = (i == 2);
            exp_q.push_back(mk(4'd7, 1, 0, 16'h0, 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL hit_drop_%0d: got %h want %h", i, obs_a, e); end
        end
    endtask

    task automatic test_invuln();
        for (int i = 1; i <= 60; i++) begin
            frame_tick = 1;
            hit = (i == 60);
            exp_q.push_back(mk(4'd7, (i < 60), 0, 16'h0, 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL invuln_tick_%0d: got %h want %h", i, obs_a, e); end
        end
        hit = 1;
        exp_q.push_back(mk(4'd6, 1, 0, 16'h0, 16'h0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL hit_after_window: got %h want %h", obs_a, e); end
    endtask

    task automatic test_dead();
        // stim = {game_reset, hit, heal, frame_tick}; exp = {hp, invuln, dead}
        dead_stim = '{4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0010,
                      4'b0001, 4'b0100, 4'b0010, 4'b1110, 4'b0100, 4'b1000};
        dead_exp  = '{{4'd5,2'b10}, {4'd5,2'b00}, {4'd2,2'b10}, {4'd2,2'b00},
                      {4'd0,2'b11}, {4'd0,2'b11}, {4'd0,2'b01}, {4'd0,2'b01},
                      {4'd0,2'b01}, {4'd8,2'b00}, {4'd5,2'b10}, {4'd8,2'b00}};
        do_reset();
        game_state = PLAY;
        for (int i = 0; i < 12; i++) begin
            {game_reset, hit, heal, frame_tick} = dead_stim[i];
            expb_q.push_back(mk(dead_exp[i][5:2], dead_exp[i][1], dead_exp[i][0], 16'h0, 16'h0));
            cycle();
            e = expb_q.pop_front(); checks++;
            if (obs_b !== e) begin errors++; $display("FAIL dead_step_%0d: got %h want %h", i, obs_b, e); end
        end
    endtask

    task automatic test_coin();
        int v;
        logic [3:0] vals [5];
        vals = '{4'd9, 4'd9, 4'd7, 4'd10, 4'd0};
        do_reset();
        game_state = PLAY;
        m_score = 0;
        for (int i = 0; i < 5; i++) begin
            coin = 1; coin_val = vals[i];
            if (vals[i] >= 4'd1 && vals[i] <= 4'd9) m_score += int'(vals[i]);
            exp_q.push_back(mk(4'd8, 0, 0, to_bcd(m_score), 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL coin_%0d: got %h want %h", i, obs_a, e); end
        end
        while (m_score < 9995) begin
            v = (9995 - m_score >= 9) ? 9 : 9995 - m_score;
            coin = 1; coin_val = 4'(v);
            m_score += v;
            exp_q.push_back(mk(4'd8, 0, 0, to_bcd(m_score), 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL coin_ramp: got %h want %h", obs_a, e); end
        end
        for (int i = 0; i < 3; i++) begin
            coin = 1; coin_val = (i == 0) ? 4'd7 : 4'd1;
            score_reset = (i == 2);
            exp_q.push_back(mk(4'd8, 0, 0, (i == 2) ? 16'h0000 : 16'h9999, 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL coin_sat_%0d: got %h want %h", i, obs_a, e); end
        end
    endtask

    task automatic test_hi_score();
        // stim = {game_state, score_reset, coin, coin_val}; exp = {score, hi}
        logic [7:0]  st [12];
        logic [31:0] ex [12];
        st = '{{2'b01,2'b01,4'd9}, {2'b01,2'b01,4'd9}, {2'b01,2'b01,4'd7},
               {2'b10,2'b01,4'd5}, {2'b01,2'b00,4'd0}, {2'b01,2'b10,4'd0},
               {2'b01,2'b01,4'd9}, {2'b01,2'b01,4'd1}, {2'b00,2'b00,4'd0},
               {2'b01,2'b01,4'd9}, {2'b11,2'b01,4'd3}, {2'b11,2'b01,4'd3}};
        ex = '{{16'h0009,16'h0000}, {16'h0018,16'h0000}, {16'h0025,16'h0000},
               {16'h0025,16'h0025}, {16'h0025,16'h0025}, {16'h0000,16'h0025},
               {16'h0009,16'h0025}, {16'h0010,16'h0025}, {16'h0010,16'h0025},
               {16'h0019,16'h0025}, {16'h0019,16'h0025}, {16'h0019,16'h0025}};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            {game_state, score_reset, coin, coin_val} = st[i];
            exp_q.push_back(mk(4'd8, 0, 0, ex[i][31:16], ex[i][15:0]));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL hi_step_%0d: got %h want %h", i, obs_a, e); end
        end
    endtask

    task automatic test_menu_freeze();
        logic [3:0] h;
        do_reset();
        game_state = MENU;
        hit = 1; heal = 1; coin = 1; coin_val = 4'd5; frame_tick = 1;
        exp_q.push_back(mk(4'd8, 0, 0, 16'h0, 16'h0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL menu_events: got %h want %h", obs_a, e); end
        game_state = PLAY; hit = 1;
        exp_q.push_back(mk(4'd7, 1, 0, 16'h0, 16'h0));
        cycle();
        e = exp_q.pop_front(); checks++;
        if (obs_a !== e) begin errors++; $display("FAIL menu_prehit: got %h want %h", obs_a, e); end
        game_state = MENU;
        for (int i = 0; i < 70; i++) begin
            frame_tick = 1; hit = (i == 35); heal = (i == 36);
            exp_q.push_back(mk(4'd7, 1, 0, 16'h0, 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL menu_frozen_%0d: got %h want %h", i, obs_a, e); end
        end
        game_state = PLAY;
        h = 4'd7;
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 60; i++) begin
                frame_tick = 1;
                exp_q.push_back(mk(h, (i < 60), 0, 16'h0, 16'h0));
                cycle();
                e = exp_q.pop_front(); checks++;
                if (obs_a !== e) begin errors++; $display("FAIL play_tick_%0d_%0d: got %h want %h", r, i, obs_a, e); end
            end
            if (r < 2) begin
                hit = 1; h = h - 4'd1;
                exp_q.push_back(mk(h, 1, 0, 16'h0, 16'h0));
                cycle();
                e = exp_q.pop_front(); checks++;
                if (obs_a !== e) begin errors++; $display("FAIL play_hit_%0d: got %h want %h", r, obs_a, e); end
            end
        end
    endtask

    task automatic test_hit_heal();
        // hp 5 -> hit+heal accepted hit wins (4); rejected hit lets heal apply; ceiling at 8.
        logic [3:0] exp_hp [6];
        exp_hp = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd8};
        for (int i = 0; i < 6; i++) begin
            hit = (i < 2); heal = 1;
            exp_q.push_back(mk(exp_hp[i], 1, 0, 16'h0, 16'h0));
            cycle();
            e = exp_q.pop_front(); checks++;
            if (obs_a !== e) begin errors++; $display("FAIL hit_heal_%0d: got %h want %h", i, obs_a, e); end
        end
    endtask

    initial begin
        Reset = 1; frame_tick = 0; game_reset = 0; score_reset = 0;
        hit = 0; heal = 0; coin = 0; coin_val = 4'd0; game_state = MENU;
        #1;
        test_reset();
        test_hit();
        test_invuln();
        test_dead();
        test_coin();
        test_hi_score();
        test_menu_freeze();
        test_hit_heal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
